// File: rtl/sram_resp_pkg.sv
// Shared types and constants for the SLC-3 memory-side responder.
package sram_resp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_HOLD = 2'd2
    } resp_state_e;

    localparam int          CNT_W            = 3;
    localparam logic [15:0] PROT_TOP_DEFAULT = 16'h00FF;

endpackage

// File: rtl/sram_resp_array.sv
// Single-port word store with a synchronous write and an asynchronous read.
// There is no reset, so the store can map onto block RAM.
module sram_resp_array #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/sram_responder.sv
// SLC-3 memory responder: programmable read latency, one-cycle Ready pulse.
// Define SRAM_RESP_PROT_EN to block writes at or below PROT_TOP.
module sram_responder
    import sram_resp_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter int          READ_LAT = 2,
    parameter logic [15:0] PROT_TOP = PROT_TOP_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [15:0] ADDR,
    input  logic        OE,
    input  logic        WE,
    input  logic [15:0] Data_to_SRAM,
    output logic [15:0] Data_from_SRAM,
    output logic        Ready,
    output logic        Prot_Err
);

    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(READ_LAT - 1);

    resp_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              ready_q, ready_d;
    logic              prot_err_q, prot_err_d;

    logic              write_req;
    logic              write_blocked;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_rdata;

    assign write_req = ~WE;

`ifdef SRAM_RESP_PROT_EN
    assign write_blocked = (ADDR <= PROT_TOP);
`else
    logic unused_prot;
    assign write_blocked = 1'b0;
    assign unused_prot   = ^{ADDR[15:ADDR_W], PROT_TOP};
`endif

    // The single port serves the write address while WE is low, otherwise the latched read address.
    assign mem_addr = write_req ? ADDR[ADDR_W-1:0] : addr_q;

    sram_resp_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (16)
    ) u_array (
        .clk   (Clk),
        .we    (write_req & ~write_blocked),
        .addr  (mem_addr),
        .wdata (Data_to_SRAM),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        ready_d    = 1'b0;
        prot_err_d = prot_err_q;

        if (write_req) begin
            state_d = IDLE;
            cnt_d   = '0;
            ready_d = 1'b1;
            if (write_blocked) begin
                prot_err_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (!OE) begin
                        addr_d  = ADDR[ADDR_W-1:0];
                        cnt_d   = LAT_INIT;
                        state_d = RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == '0) begin
                        data_d  = mem_rdata;
                        ready_d = 1'b1;
                        state_d = RD_HOLD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                RD_HOLD: begin
                    if (OE) begin
                        state_d = IDLE;
                    end else if (ADDR[ADDR_W-1:0] != addr_q) begin
                        addr_d  = ADDR[ADDR_W-1:0];
                        cnt_d   = LAT_INIT;
                        state_d = RD_WAIT;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            ready_q    <= 1'b0;
            prot_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            prot_err_q <= prot_err_d;
        end
    end

    assign Data_from_SRAM = data_q;
    assign Ready          = ready_q;
    assign Prot_Err       = prot_err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder (READ_LAT=2, ADDR_W=10), honouring SRAM_RESP_PROT_EN.
module tb_sram_responder;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic [15:0] ADDR = 16'h0000;
    logic        OE = 1'b1;
    logic        WE = 1'b1;
    logic [15:0] Data_to_SRAM = 16'h0000;
    logic [15:0] Data_from_SRAM;
    logic        Ready;
    logic        Prot_Err;

    int checks = 0;
    int errors = 0;

    sram_responder #(
        .ADDR_W   (10),
        .READ_LAT (2),
        .PROT_TOP (16'h00FF)
    ) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .ADDR           (ADDR),
        .OE             (OE),
        .WE             (WE),
        .Data_to_SRAM   (Data_to_SRAM),
        .Data_from_SRAM (Data_from_SRAM),
        .Ready          (Ready),
        .Prot_Err       (Prot_Err)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [15:0] addr, input logic [15:0] data);
        ADDR         = addr;
        Data_to_SRAM = data;
        WE           = 1'b0;
        tick();
        WE           = 1'b1;
    endtask

    // Full read: accept edge, one wait edge, completion edge, then release OE and idle.
    task automatic do_read(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        ADDR = addr;
        OE   = 1'b0;
        tick();
        tick();
        tick();
        check_output({tag, "_ready"}, 16'(Ready), 16'h0001);
        check_output({tag, "_data"}, Data_from_SRAM, exp);
        OE = 1'b1;
        tick();
    endtask

    initial begin
        #2 Reset_n = 1'b0;
        #1;
        check_output("rst_data", Data_from_SRAM, 16'h0000);
        check_output("rst_ready", 16'(Ready), 16'h0000);
        check_output("rst_prot", 16'(Prot_Err), 16'h0000);
        tick();
        tick();
        Reset_n = 1'b1;
        tick();

        apply_stimulus(16'h0300, 16'h1234);
        check_output("wr_ready", 16'(Ready), 16'h0001);
        apply_stimulus(16'h0301, 16'hBEEF);

        ADDR = 16'h0300;
        OE   = 1'b0;
        tick();
        check_output("lat_e1_ready", 16'(Ready), 16'h0000);
        tick();
        check_output("lat_e2_ready", 16'(Ready), 16'h0000);
        check_output("lat_e2_data", Data_from_SRAM, 16'h0000);
        tick();
        check_output("lat_e3_ready", 16'(Ready), 16'h0001);
        check_output("lat_e3_data", Data_from_SRAM, 16'h1234);
        tick();
        check_output("hold_ready", 16'(Ready), 16'h0000);
        check_output("hold_data", Data_from_SRAM, 16'h1234);

        ADDR = 16'h0301;
        tick();
        check_output("reacc_e1_ready", 16'(Ready), 16'h0000);
        tick();
        check_output("reacc_e2_ready", 16'(Ready), 16'h0000);
        tick();
        check_output("reacc_ready", 16'(Ready), 16'h0001);
        check_output("reacc_data", Data_from_SRAM, 16'hBEEF);
        tick();
        check_output("reacc_hold1", 16'(Ready), 16'h0000);
        tick();
        check_output("reacc_hold2", 16'(Ready), 16'h0000);
        check_output("reacc_hold_data", Data_from_SRAM, 16'hBEEF);
        OE = 1'b1;
        tick();

        ADDR         = 16'h0010;
        Data_to_SRAM = 16'hAAAA;
        WE           = 1'b0;
        OE           = 1'b0;
        tick();
        WE = 1'b1;
        OE = 1'b1;
        check_output("both_ready", 16'(Ready), 16'h0001);
        tick();
        check_output("both_noread_ready", 16'(Ready), 16'h0000);
        check_output("both_noread_data", Data_from_SRAM, 16'hBEEF);
`ifdef SRAM_RESP_PROT_EN
        check_output("prot_err_set", 16'(Prot_Err), 16'h0001);
        tick();
        check_output("prot_err_sticky", 16'(Prot_Err), 16'h0001);
`else
        check_output("prot_err_off", 16'(Prot_Err), 16'h0000);
        do_read("both_rb", 16'h0010, 16'hAAAA);
`endif

        apply_stimulus(16'h0405, 16'h5555);
        tick();
        do_read("alias", 16'h0005, 16'h5555);

        ADDR = 16'h0300;
        OE   = 1'b0;
        tick();
        #2 Reset_n = 1'b0;
        #1;
        check_output("midrst_data", Data_from_SRAM, 16'h0000);
        check_output("midrst_ready", 16'(Ready), 16'h0000);
        OE = 1'b1;
        #3 Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("midrst_no_ready", 16'(Ready), 16'h0000);
        end
        do_read("midrst_rb1", 16'h0300, 16'h1234);
        do_read("midrst_rb2", 16'h0005, 16'h5555);

        ADDR = 16'h0301;
        OE   = 1'b0;
        tick();
        ADDR         = 16'h0302;
        Data_to_SRAM = 16'h7777;
        WE           = 1'b0;
        tick();
        WE = 1'b1;
        OE = 1'b1;
        check_output("abort_wr_ready", 16'(Ready), 16'h0001);
        check_output("abort_data_e1", Data_from_SRAM, 16'h5555);
        tick();
        check_output("abort_no_ready1", 16'(Ready), 16'h0000);
        check_output("abort_data_e2", Data_from_SRAM, 16'h5555);
        tick();
        check_output("abort_no_ready2", 16'(Ready), 16'h0000);
        check_output("abort_data_e3", Data_from_SRAM, 16'h5555);
        do_read("abort_rb", 16'h0302, 16'h7777);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
